// File: rtl/dma_read_port_pkg.sv
// Shared definitions for the engine memory ports: controller instruction codes,
// port FSM state encodings and the 32-bit memory word layout. The write-port
// block is expected to import these same definitions.
package dma_read_port_pkg;

  // Memory-controller instruction codes
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Port FSM state encodings, kept as plain constants so older tools and the
  // legacy write-port code can share them unchanged
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_EMIT_LO = 3'd3;
  localparam logic [2:0] ST_EMIT_HI = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // One controller data word holds two fp16 values, the low half first in address order
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } mem_word_t;

endpackage

// File: rtl/dma_read_port_if.sv
// Bus bundle between one engine read port and its memory-controller user port.
// master = the port logic (issues controller commands, drives engine strobes),
// slave  = the surrounding engine / controller side.
interface dma_read_port_if #(
  parameter int ADDR_W = 30
);

  // Engine side
  logic              reads_en;
  logic [ADDR_W-1:0] addr;
  logic              ob_we;
  logic [15:0]       ob_data;
  logic              burst_done;
  logic              addr_err;

  // Controller command side
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_byte_addr;
  logic              cmd_full;

  // Controller read-data side (first-word-fall-through FIFO)
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_empty;

  modport master (
    input  reads_en, addr, cmd_full, rd_data, rd_empty,
    output ob_we, ob_data, burst_done, addr_err,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en
  );

  modport slave (
    output reads_en, addr, cmd_full, rd_data, rd_empty,
    input  ob_we, ob_data, burst_done, addr_err,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en
  );

endinterface

// File: rtl/dma_read_port.sv
// Engine read port responder: on a request it issues one burst read to the
// memory controller, then unpacks each returned 32-bit word into two fp16
// halfwords (low half first) and strobes them to the engine. One burst is
// outstanding at a time; a request seen in IDLE always runs to completion.
module dma_read_port
  import dma_read_port_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 30
) (
  input  logic            clk,
  input  logic            rst,
  dma_read_port_if.master bus
);

  localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [5:0]       CMD_BL    = 6'(BURST_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  mem_word_t         word_q, word_d;
  logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
  logic              ob_we_q, ob_we_d;
  logic [15:0]       ob_data_q, ob_data_d;
  logic              burst_done_q, burst_done_d;
  logic              addr_err_q, addr_err_d;
  logic              cmd_en_q, cmd_en_d;
  logic              rd_en_q, rd_en_d;

  // The halfword address MSB falls off when converting to a byte address
  // (the byte address space wraps at the top)
  logic              addr_msb_unused_s;
  assign addr_msb_unused_s = bus.addr[ADDR_W-1];

  // Next-state and next-output decode for the burst FSM
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    byte_addr_d  = byte_addr_q;
    ob_data_d    = ob_data_q;
    ob_we_d      = 1'b0;
    burst_done_d = 1'b0;
    addr_err_d   = 1'b0;
    cmd_en_d     = 1'b0;
    rd_en_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.reads_en) begin
          // Halfword address -> byte address, aligned down to a 32-bit word
          byte_addr_d = {bus.addr[ADDR_W-2:1], 2'b00};
          word_cnt_d  = '0;
          addr_err_d  = bus.addr[0];
          state_d     = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (!bus.cmd_full) begin
          cmd_en_d = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_FETCH: begin
        if (!bus.rd_empty) begin
          // FWFT: data is already valid, the pop strobe retires it
          rd_en_d = 1'b1;
          word_d  = mem_word_t'(bus.rd_data);
          state_d = ST_EMIT_LO;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EMIT_LO: begin
        ob_we_d   = 1'b1;
        ob_data_d = word_q.lo;
        state_d   = ST_EMIT_HI;
      end

      ST_EMIT_HI: begin
        ob_we_d   = 1'b1;
        ob_data_d = word_q.hi;
        if (word_cnt_q == LAST_WORD) begin
          state_d = ST_DONE;
        end else begin
          word_cnt_d = word_cnt_q + CNT_ONE;
          state_d    = ST_FETCH;
        end
      end

      ST_DONE: begin
        burst_done_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      word_q       <= '0;
      byte_addr_q  <= '0;
      ob_we_q      <= 1'b0;
      ob_data_q    <= 16'h0000;
      burst_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      cmd_en_q     <= 1'b0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      byte_addr_q  <= byte_addr_d;
      ob_we_q      <= ob_we_d;
      ob_data_q    <= ob_data_d;
      burst_done_q <= burst_done_d;
      addr_err_q   <= addr_err_d;
      cmd_en_q     <= cmd_en_d;
      rd_en_q      <= rd_en_d;
    end
  end

  assign bus.ob_we         = ob_we_q;
  assign bus.ob_data       = ob_data_q;
  assign bus.burst_done    = burst_done_q;
  assign bus.addr_err      = addr_err_q;
  assign bus.cmd_en        = cmd_en_q;
  assign bus.cmd_instr     = CMD_READ;
  assign bus.cmd_bl        = CMD_BL;
  assign bus.cmd_byte_addr = byte_addr_q;
  assign bus.rd_en         = rd_en_q;

endmodule

// File: tb/tb_dma_read_port.sv
// Self-checking bench for dma_read_port: two instances (BURST_LEN 4 and 16),
// each attached to a behavioural FWFT memory-controller model fed from a
// shared memory array. Expected halfword streams come from the address rule
// and memory contents, independent of the port's internal structure.
module tb_dma_read_port;

  localparam int ADDR_W    = 30;
  localparam int MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_read_port_if #(.ADDR_W(ADDR_W)) bus4 ();
  dma_read_port_if #(.ADDR_W(ADDR_W)) bus16 ();

  dma_read_port #(.BURST_LEN(4), .ADDR_W(ADDR_W)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  dma_read_port #(.BURST_LEN(16), .ADDR_W(ADDR_W)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.master)
  );

  // Scoreboard state, index 0 = bus4, index 1 = bus16
  logic [31:0]       mem      [MEM_WORDS];
  logic [31:0]       pend_q   [2][$];
  logic [31:0]       fifo_q   [2][$];
  logic [15:0]       got_q    [2][$];
  logic [ADDR_W-1:0] cmd_addr_q [2][$];
  int                done_size_q [2][$];
  logic [15:0]       exp_q    [$];
  int                cmd_cnt  [2];
  int                rd_cnt   [2];
  int                done_cnt [2];
  int                err_cnt  [2];
  int                bad_cnt  [2];
  int                arrive_pct = 100;
  int                n_checks = 0;
  int                n_pass   = 0;

  // Controller model and output monitor: observe mid-cycle, update after the edge
  initial begin : ctrl_model
    logic              s_cmd   [2];
    logic              s_rd    [2];
    logic [ADDR_W-1:0] s_caddr [2];
    logic              rst_edge;
    int                base;
    int                bl;
    for (int k = 0; k < 2; k++) begin
      s_cmd[k] = 1'b0; s_rd[k] = 1'b0; s_caddr[k] = '0;
      cmd_cnt[k] = 0; rd_cnt[k] = 0; done_cnt[k] = 0; err_cnt[k] = 0; bad_cnt[k] = 0;
    end
    bus4.rd_empty = 1'b1;  bus4.rd_data = 32'h0;
    bus16.rd_empty = 1'b1; bus16.rd_data = 32'h0;
    forever begin
      @(negedge clk);
      s_cmd[0] = bus4.cmd_en;  s_rd[0] = bus4.rd_en;  s_caddr[0] = bus4.cmd_byte_addr;
      s_cmd[1] = bus16.cmd_en; s_rd[1] = bus16.rd_en; s_caddr[1] = bus16.cmd_byte_addr;
      if (bus4.ob_we)       got_q[0].push_back(bus4.ob_data);
      if (bus16.ob_we)      got_q[1].push_back(bus16.ob_data);
      if (bus4.burst_done)  begin done_cnt[0]++; done_size_q[0].push_back(got_q[0].size()); end
      if (bus16.burst_done) begin done_cnt[1]++; done_size_q[1].push_back(got_q[1].size()); end
      if (bus4.addr_err)    err_cnt[0]++;
      if (bus16.addr_err)   err_cnt[1]++;
      for (int k = 0; k < 2; k++) begin
        if (s_cmd[k]) begin cmd_cnt[k]++; cmd_addr_q[k].push_back(s_caddr[k]); end
        if (s_rd[k])  rd_cnt[k]++;
      end
      @(posedge clk);
      rst_edge = rst;
      #1;
      for (int k = 0; k < 2; k++) begin
        bl = (k == 0) ? 4 : 16;
        if (!rst_edge) begin
          pend_q[k].delete();
          fifo_q[k].delete();
        end else begin
          if (s_rd[k]) begin
            if (fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
            else bad_cnt[k]++;
          end
          if (s_cmd[k]) begin
            base = int'(s_caddr[k] >> 2) % MEM_WORDS;
            for (int i = 0; i < bl; i++) pend_q[k].push_back(mem[(base + i) % MEM_WORDS]);
          end
          if (pend_q[k].size() > 0 && $urandom_range(99) < arrive_pct)
            fifo_q[k].push_back(pend_q[k].pop_front());
        end
      end
      bus4.rd_empty  = (fifo_q[0].size() == 0);
      bus4.rd_data   = (fifo_q[0].size() > 0) ? fifo_q[0][0] : 32'h0;
      bus16.rd_empty = (fifo_q[1].size() == 0);
      bus16.rd_data  = (fifo_q[1].size() > 0) ? fifo_q[1][0] : 32'h0;
    end
  end

  // Absolute time limit so the bench can never hang
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Byte address the controller should see: halfword address doubled, aligned down, wrapped
  function automatic logic [ADDR_W-1:0] exp_byte_addr(input logic [ADDR_W-1:0] haddr);
    logic [ADDR_W+1:0] wide;
    wide = {2'b00, haddr} * 2;
    wide = wide & ~((ADDR_W+2)'(3));
    return wide[ADDR_W-1:0];
  endfunction

  task automatic append_exp(input logic [ADDR_W-1:0] haddr, input int bl);
    int          base;
    logic [31:0] w;
    base = int'(exp_byte_addr(haddr) / 4) % MEM_WORDS;
    for (int i = 0; i < bl; i++) begin
      w = mem[(base + i) % MEM_WORDS];
      exp_q.push_back(w[15:0]);
      exp_q.push_back(w[31:16]);
    end
  endtask

  function automatic int count_diff(input int k);
    int n;
    n = 0;
    if (got_q[k].size() != exp_q.size()) n++;
    for (int i = 0; i < exp_q.size() && i < got_q[k].size(); i++)
      if (got_q[k][i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic clear_obs(input int k);
    got_q[k].delete(); cmd_addr_q[k].delete(); done_size_q[k].delete(); exp_q.delete();
    cmd_cnt[k] = 0; rd_cnt[k] = 0; done_cnt[k] = 0; err_cnt[k] = 0; bad_cnt[k] = 0;
  endtask

  task automatic drive_req(input int k, input logic en, input logic [ADDR_W-1:0] a);
    if (k == 0) begin bus4.reads_en = en; bus4.addr = a; end
    else begin bus16.reads_en = en; bus16.addr = a; end
  endtask

  task automatic wait_done(input int k, input int target, input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt[k] < target && n < budget) begin tick(); n++; end
    timed_out = (done_cnt[k] < target);
  endtask

  function automatic logic [ADDR_W-1:0] rand_even();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[0] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    drive_req(0, 1'b0, '0); drive_req(1, 1'b0, '0);
    bus4.cmd_full = 1'b0; bus16.cmd_full = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus4.ob_we !== 1'b0) $display("FAIL rst_ob_we: got %0h expected 0", bus4.ob_we); else n_pass++;
    n_checks++; if (bus4.ob_data !== 16'h0) $display("FAIL rst_ob_data: got %0h expected 0", bus4.ob_data); else n_pass++;
    n_checks++; if (bus4.cmd_en !== 1'b0) $display("FAIL rst_cmd_en: got %0h expected 0", bus4.cmd_en); else n_pass++;
    n_checks++; if (bus4.rd_en !== 1'b0) $display("FAIL rst_rd_en: got %0h expected 0", bus4.rd_en); else n_pass++;
    n_checks++; if (bus4.burst_done !== 1'b0) $display("FAIL rst_burst_done: got %0h expected 0", bus4.burst_done); else n_pass++;
    n_checks++; if (bus4.addr_err !== 1'b0) $display("FAIL rst_addr_err: got %0h expected 0", bus4.addr_err); else n_pass++;
    n_checks++; if (bus4.cmd_byte_addr !== 30'h0) $display("FAIL rst_cmd_addr: got %0h expected 0", bus4.cmd_byte_addr); else n_pass++;
    n_checks++; if (bus4.cmd_instr !== 3'b001) $display("FAIL cmd_instr: got %0h expected 1", bus4.cmd_instr); else n_pass++;
    n_checks++; if (bus4.cmd_bl !== 6'd3) $display("FAIL cmd_bl_4: got %0d expected 3", bus4.cmd_bl); else n_pass++;
    n_checks++; if (bus16.cmd_bl !== 6'd15) $display("FAIL cmd_bl_16: got %0d expected 15", bus16.cmd_bl); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    mem[8] = 32'h3413_3a07; mem[9] = 32'h378a_382f; mem[10] = 32'h3af5_2d2d; mem[11] = 32'h38db_2e19;
    clear_obs(0);
    append_exp(30'h10, 4);
    drive_req(0, 1'b1, 30'h10);
    tick();
    drive_req(0, 1'b0, 30'h10);
    n_checks++; if (bus4.cmd_en !== 1'b0) $display("FAIL basic_cmd_early: got %0h expected 0", bus4.cmd_en); else n_pass++;
    tick();
    n_checks++; if (bus4.cmd_en !== 1'b1) $display("FAIL basic_cmd_lat: got %0h expected 1", bus4.cmd_en); else n_pass++;
    n_checks++; if (bus4.cmd_byte_addr !== 30'h20) $display("FAIL basic_cmd_addr: got %0h expected 20", bus4.cmd_byte_addr); else n_pass++;
    tick();
    n_checks++; if (bus4.ob_we !== 1'b0) $display("FAIL basic_ob_we_early: got %0h expected 0", bus4.ob_we); else n_pass++;
    tick();
    n_checks++; if (bus4.rd_en !== 1'b1) $display("FAIL basic_rd_en_lat: got %0h expected 1", bus4.rd_en); else n_pass++;
    tick();
    n_checks++; if (bus4.ob_we !== 1'b1 || bus4.ob_data !== 16'h3a07)
      $display("FAIL basic_first_ob: got we=%0h data=%0h expected we=1 data=3a07", bus4.ob_we, bus4.ob_data); else n_pass++;
    wait_done(0, 1, 200, to);
    repeat (6) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL basic_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (count_diff(0) !== 0)
      $display("FAIL basic_data: %0d diffs, got %0d halfwords expected %0d", count_diff(0), got_q[0].size(), exp_q.size()); else n_pass++;
    n_checks++; if (cmd_cnt[0] !== 1) $display("FAIL basic_cmd_cnt: got %0d expected 1", cmd_cnt[0]); else n_pass++;
    n_checks++; if (rd_cnt[0] !== 4) $display("FAIL basic_rd_cnt: got %0d expected 4", rd_cnt[0]); else n_pass++;
    n_checks++; if (done_cnt[0] !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (done_size_q[0].size() != 1 || done_size_q[0][0] !== 8)
      $display("FAIL basic_done_pos: done entries %0d expected 1 after 8 halfwords", done_size_q[0].size()); else n_pass++;
    n_checks++; if (err_cnt[0] !== 0) $display("FAIL basic_addr_err: got %0d expected 0", err_cnt[0]); else n_pass++;
  endtask

  task automatic test_cmd_full();
    bit                to;
    logic [ADDR_W-1:0] a;
    clear_obs(0);
    a = rand_even();
    append_exp(a, 4);
    bus4.cmd_full = 1'b1;
    drive_req(0, 1'b1, a);
    tick();
    drive_req(0, 1'b0, a);
    repeat (5) tick();
    n_checks++; if (cmd_cnt[0] !== 0) $display("FAIL full_hold: cmd_en pulses %0d expected 0", cmd_cnt[0]); else n_pass++;
    bus4.cmd_full = 1'b0;
    wait_done(0, 1, 200, to);
    repeat (4) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL full_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (cmd_cnt[0] !== 1) $display("FAIL full_cmd_cnt: got %0d expected 1", cmd_cnt[0]); else n_pass++;
    n_checks++; if (count_diff(0) !== 0) $display("FAIL full_data: %0d diffs expected 0", count_diff(0)); else n_pass++;
  endtask

  task automatic test_rd_empty_random();
    bit                to;
    logic [ADDR_W-1:0] a;
    clear_obs(0);
    a = rand_even();
    append_exp(a, 4);
    arrive_pct = 50;
    drive_req(0, 1'b1, a);
    tick();
    drive_req(0, 1'b0, a);
    wait_done(0, 1, 400, to);
    arrive_pct = 100;
    repeat (4) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL empty_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (count_diff(0) !== 0) $display("FAIL empty_data: %0d diffs expected 0", count_diff(0)); else n_pass++;
    n_checks++; if (rd_cnt[0] !== 4) $display("FAIL empty_rd_cnt: got %0d expected 4", rd_cnt[0]); else n_pass++;
    n_checks++; if (bad_cnt[0] !== 0) $display("FAIL empty_underflow: got %0d pops of empty FIFO expected 0", bad_cnt[0]); else n_pass++;
  endtask

  task automatic test_reads_en_drop();
    bit                to;
    logic [ADDR_W-1:0] a;
    clear_obs(0);
    a = rand_even();
    append_exp(a, 4);
    drive_req(0, 1'b1, a);
    repeat (3) tick();
    drive_req(0, 1'b0, a);
    wait_done(0, 1, 200, to);
    repeat (10) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL drop_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (count_diff(0) !== 0) $display("FAIL drop_data: %0d diffs expected 0", count_diff(0)); else n_pass++;
    n_checks++; if (cmd_cnt[0] !== 1) $display("FAIL drop_cmd_cnt: got %0d expected 1", cmd_cnt[0]); else n_pass++;
    n_checks++; if (done_cnt[0] !== 1) $display("FAIL drop_done_cnt: got %0d expected 1", done_cnt[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit                to;
    int                n;
    logic [ADDR_W-1:0] a;
    clear_obs(0);
    a = rand_even();
    drive_req(0, 1'b1, a);
    tick();
    drive_req(0, 1'b0, a);
    n = 0;
    while (got_q[0].size() < 3 && n < 100) begin tick(); n++; end
    n_checks++; if (got_q[0].size() !== 3) $display("FAIL mid_reach: got %0d halfwords expected 3", got_q[0].size()); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if ({bus4.ob_we, bus4.rd_en, bus4.cmd_en, bus4.burst_done, bus4.addr_err} !== 5'b0)
      $display("FAIL mid_strobes: got %b expected 00000", {bus4.ob_we, bus4.rd_en, bus4.cmd_en, bus4.burst_done, bus4.addr_err}); else n_pass++;
    n_checks++; if (bus4.cmd_byte_addr !== 30'h0) $display("FAIL mid_cmd_addr: got %0h expected 0", bus4.cmd_byte_addr); else n_pass++;
    rst = 1'b1;
    repeat (8) tick();
    n_checks++; if (got_q[0].size() !== 3 || done_cnt[0] !== 0)
      $display("FAIL mid_abandon: got %0d halfwords %0d done expected 3 and 0", got_q[0].size(), done_cnt[0]); else n_pass++;
    clear_obs(0);
    a = rand_even();
    append_exp(a, 4);
    drive_req(0, 1'b1, a);
    tick();
    drive_req(0, 1'b0, a);
    wait_done(0, 1, 200, to);
    repeat (4) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL mid_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (count_diff(0) !== 0) $display("FAIL mid_clean_data: %0d diffs expected 0", count_diff(0)); else n_pass++;
  endtask

  task automatic test_addr_err();
    bit to;
    clear_obs(0);
    append_exp(30'h11, 4);
    drive_req(0, 1'b1, 30'h11);
    tick();
    drive_req(0, 1'b0, 30'h11);
    wait_done(0, 1, 200, to);
    repeat (4) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL odd_timeout: burst_done count %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (err_cnt[0] !== 1) $display("FAIL odd_err_cnt: got %0d expected 1", err_cnt[0]); else n_pass++;
    n_checks++; if (cmd_addr_q[0].size() != 1 || cmd_addr_q[0][0] !== 30'h20)
      $display("FAIL odd_cmd_addr: %0d commands, expected one at 20", cmd_addr_q[0].size()); else n_pass++;
    n_checks++; if (count_diff(0) !== 0) $display("FAIL odd_data: %0d diffs expected 0", count_diff(0)); else n_pass++;
  endtask

  task automatic test_random();
    bit                to;
    logic [ADDR_W-1:0] a;
    int                hold;
    for (int it = 0; it < 8; it++) begin
      clear_obs(0);
      a = (it == 0) ? 30'h3FFF_FFFF : ADDR_W'($urandom);
      append_exp(a, 4);
      arrive_pct = $urandom_range(100, 30);
      hold = $urandom_range(3, 0);
      bus4.cmd_full = (hold > 0);
      drive_req(0, 1'b1, a);
      tick();
      drive_req(0, 1'b0, a);
      repeat (hold) tick();
      bus4.cmd_full = 1'b0;
      wait_done(0, 1, 400, to);
      repeat (3) tick();
      n_checks++; if (to !== 1'b0) $display("FAIL rand%0d_timeout: burst_done count %0d expected 1", it, done_cnt[0]); else n_pass++;
      n_checks++; if (count_diff(0) !== 0) $display("FAIL rand%0d_data: %0d diffs expected 0", it, count_diff(0)); else n_pass++;
      n_checks++; if (err_cnt[0] !== int'(a[0])) $display("FAIL rand%0d_err: got %0d expected %0d", it, err_cnt[0], a[0]); else n_pass++;
      n_checks++; if (cmd_addr_q[0].size() != 1 || cmd_addr_q[0][0] !== exp_byte_addr(a))
        $display("FAIL rand%0d_cmd_addr: %0d commands, expected one at %0h", it, cmd_addr_q[0].size(), exp_byte_addr(a)); else n_pass++;
    end
    arrive_pct = 100;
  endtask

  task automatic test_back_to_back();
    bit                to;
    int                n;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    clear_obs(1);
    a1 = rand_even();
    a2 = rand_even() ^ 30'h0000_0100;
    append_exp(a1, 16);
    append_exp(a2, 16);
    drive_req(1, 1'b1, a1);
    n = 0;
    while (cmd_cnt[1] < 1 && n < 50) begin tick(); n++; end
    drive_req(1, 1'b1, a2);
    wait_done(1, 2, 600, to);
    drive_req(1, 1'b0, a2);
    repeat (10) tick();
    n_checks++; if (to !== 1'b0) $display("FAIL b2b_timeout: burst_done count %0d expected 2", done_cnt[1]); else n_pass++;
    n_checks++; if (cmd_cnt[1] !== 2) $display("FAIL b2b_cmd_cnt: got %0d expected 2", cmd_cnt[1]); else n_pass++;
    n_checks++; if (count_diff(1) !== 0)
      $display("FAIL b2b_data: %0d diffs, got %0d halfwords expected %0d", count_diff(1), got_q[1].size(), exp_q.size()); else n_pass++;
    n_checks++; if (done_size_q[1].size() != 2 || done_size_q[1][0] !== 32 || done_size_q[1][1] !== 64)
      $display("FAIL b2b_done_pos: %0d done pulses, expected after 32 and 64 halfwords", done_size_q[1].size()); else n_pass++;
    n_checks++; if (cmd_addr_q[1].size() != 2 || cmd_addr_q[1][0] !== exp_byte_addr(a1) || cmd_addr_q[1][1] !== exp_byte_addr(a2))
      $display("FAIL b2b_cmd_addr: %0d commands, expected %0h then %0h", cmd_addr_q[1].size(), exp_byte_addr(a1), exp_byte_addr(a2)); else n_pass++;
  endtask

  initial begin : main
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_cmd_full();
    test_rd_empty_random();
    test_reads_en_drop();
    test_reset_mid();
    test_addr_err();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
